dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-master arbiter for the single-port data RAM (RAM_B). Master 0 is the pipelined CPU data port; master 1 is a
//  secondary bus master (loader/DMA). Muxes address, write data and byte-enables onto the RAM port and routes read data back.
//  Read data is tagged with rvalid one cycle later. Sits between dm_controller/MIO_BUS and RAM_B.
// PARAMETERS
//  AW          10   word-address width (RAM depth 2**AW words)
//  RR_MODE     0    0 = fixed priority M0 with starvation guard; 1 = round-robin
//  STARVE_MAX  4    consecutive cycles M1 may wait while M0 wins before M1 is forced a grant (RR_MODE=0 only); >=1
//  LOCK_MAX    8    max cycles one master may hold a lock before forced release; >=1
// PORTS
//  clk          in   1    system clock; all state updates on rising edge
//  rstn         in   1    asynchronous reset, active low
//  m0_req       in   1    M0 access request (held until granted)
//  m0_we        in   1    M0 write (1) / read (0)
//  m0_lock      in   1    M0 requests to keep ownership after this grant
//  m0_addr      in   AW   M0 word address
//  m0_wdata     in   32   M0 write data
//  m0_wstrb     in   4    M0 byte enables (write only)
//  m0_gnt       out  1    M0 access issued to RAM this cycle
//  m0_rvalid    out  1    M0 read data valid
//  m0_rdata     out  32   M0 read data
//  m1_*         -    -    identical set for master 1 (m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata)
//  ram_addr     out  AW   RAM address
//  ram_din      out  32   RAM write data
//  ram_wea      out  4    RAM byte write enables
//  ram_dout     in   32   RAM read data (synchronous, 1-cycle latency)
//  conflict_cnt out  16   saturating count of cycles where both masters requested and one was stalled
// BEHAVIOUR
//  - Reset (rstn=0, async): state=IDLE, m*_rvalid=0, last_owner=M1, starve_cnt=0, lock_cnt=0, conflict_cnt=0;
//    m*_gnt=0 and ram_wea=0 while rstn=0.
//  - One RAM access per cycle. Grant is combinational from req and registered state; the granted master's
//    addr/wdata drive ram_addr/ram_din the same cycle; ram_wea = wstrb if granted&we, else 0.
//  - No grant: ram_addr holds M0 addr, ram_wea=0. m0_gnt & m1_gnt never both 1.
//  - Read latency: granted read in cycle N -> m*_rvalid=1 in cycle N+1, m*_rdata=ram_dout. Writes give no rvalid.
//    m*_rdata is passthrough of ram_dout; valid only while rvalid=1.
//  - States: IDLE, LOCK0, LOCK1.
//    IDLE: arbitrate. Single requester wins. Both requesting:
//      RR_MODE=1 -> master != last_owner wins.
//      RR_MODE=0 -> M0 wins unless starve_cnt==STARVE_MAX, then M1 wins.
//      Winner with lock=1 -> LOCKx, lock_cnt=1.
//    LOCKx: only master x can be granted; the other stalls.
//      -> IDLE when x drops req or lock, or when lock_cnt==LOCK_MAX (this cycle grant still to x if req).
//  - starve_cnt: +1 when M1 req & not granted; cleared when M1 granted or M1 req=0; saturates at STARVE_MAX.
//  - last_owner updates on every grant.
//  - conflict_cnt: +1 when m0_req & m1_req; holds at 16'hFFFF.
//  - Requests while in LOCKx from the other master are not lost; requester must hold req (no queueing).
//  - Reset mid-read: pending rvalid is dropped (0 after reset).
// TESTING
//  1 M0 read addr 0x010, M1 idle -> m0_gnt same cycle, ram_addr=0x010, m0_rvalid=1 next cycle with RAM word.
//  2 RR_MODE=0, both req continuously -> M0 granted 4 cycles, M1 on 5th, repeat; conflict_cnt increments every cycle.
//  3 RR_MODE=1, both req -> grants alternate M0,M1,M0...; first grant M0 after reset.
//  4 M1 write, lock=1 held, M0 req -> M1 granted 8 cycles (LOCK_MAX), then M0 granted; ram_wea=0 on M0 reads.
//  5 M0 write wstrb=4'b0011 data 0xAABBCCDD addr 0x3FF -> ram_wea=0011 one cycle, readback low half 0xCCDD only.
//  6 Assert rstn=0 the cycle after a granted read -> m0_rvalid=0, gnt=0, conflict_cnt=0 immediately.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-master arbiter in front of the single-port data RAM. Master 0 is the
// pipelined CPU data port, master 1 a secondary bus master (loader/DMA).
// One RAM access is issued per cycle; the granted master's address, write
// data and byte enables drive the RAM port in the same cycle, and read data
// returns one cycle later tagged with that master's rvalid.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   m{0,1}_req/we/lock        access request, write select, keep-ownership
//   m{0,1}_addr/wdata/wstrb   word address, write data, byte enables
//   m{0,1}_gnt                access issued to the RAM this cycle
//   m{0,1}_rvalid/rdata       read return (rdata is a passthrough of ram_dout)
//   ram_addr/din/wea/dout     RAM port (dout has 1-cycle latency)
//   conflict_cnt              saturating count of cycles with both requesting
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate between requesters every cycle
// LOCK0 | master 0 owns the RAM; master 1 stalls
// LOCK1 | master 1 owns the RAM; master 0 stalls
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 10,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic [3:0]    ram_wea,
  input  logic [31:0]   ram_dout,
  output logic [15:0]   conflict_cnt
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
  // Last grant of a lock tenure: the tenure issues at most LOCK_MAX grants,
  // counting the IDLE grant that opened it.
  localparam logic [LCW-1:0] LOCK_LAST  = LCW'(LOCK_MAX - 1);
  localparam logic [15:0]    CONF_TOP   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LCW-1:0]   r_lock_cnt;
  logic [LCW-1:0]   w_lock_cnt_nxt;
  logic [SCW-1:0]   r_starve_cnt;
  logic             r_last_owner;   // 0 = M0, 1 = M1
  logic [15:0]      r_conflict_cnt;
  logic             r_m0_rvalid;
  logic             r_m1_rvalid;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_both;
  logic             w_m1_wins_tie;

  assign w_both = m0_req & m1_req;

  // Tie-break used only in IDLE when both masters request.
  always_comb begin
    w_m1_wins_tie = 1'b0;
    if (RR_MODE != 0) begin
      w_m1_wins_tie = (r_last_owner == 1'b0);
    end else begin
      w_m1_wins_tie = (r_starve_cnt == STARVE_TOP);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_req && !(m1_req && w_m1_wins_tie)) begin
          w_gnt0 = 1'b1;
        end else if (m1_req) begin
          w_gnt1 = 1'b1;
        end
        // With LOCK_MAX == 1 the opening grant already fills the tenure,
        // so the lock is never entered.
        if (LOCK_MAX > 1) begin
          if (w_gnt0 && m0_lock) begin
            w_state_nxt    = ST_LOCK0;
            w_lock_cnt_nxt = LCW'(1);
          end else if (w_gnt1 && m1_lock) begin
            w_state_nxt    = ST_LOCK1;
            w_lock_cnt_nxt = LCW'(1);
          end
        end
      end
      ST_LOCK0: begin
        w_gnt0 = m0_req;
        if (!m0_req || !m0_lock || (r_lock_cnt >= LOCK_LAST)) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
      end
      ST_LOCK1: begin
        w_gnt1 = m1_req;
        if (!m1_req || !m1_lock || (r_lock_cnt >= LOCK_LAST)) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
    // No access may reach the RAM while reset is asserted.
    if (!rstn) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_starve_cnt <= '0;
    end else if (!m1_req || w_gnt1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_TOP) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_owner <= 1'b1;
    end else if (w_gnt0) begin
      r_last_owner <= 1'b0;
    end else if (w_gnt1) begin
      r_last_owner <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != CONF_TOP)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_gnt0 & ~m0_we;
      r_m1_rvalid <= w_gnt1 & ~m1_we;
    end
  end

  // Without a grant the port idles on M0's address with writes disabled.
  always_comb begin
    ram_addr = m0_addr;
    ram_din  = m0_wdata;
    ram_wea  = 4'b0000;
    if (w_gnt1) begin
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
      if (m1_we) ram_wea = m1_wstrb;
    end else if (w_gnt0) begin
      if (m0_we) ram_wea = m0_wstrb;
    end
  end

  assign m0_gnt       = w_gnt0;
  assign m1_gnt       = w_gnt1;
  assign m0_rvalid    = r_m0_rvalid;
  assign m1_rvalid    = r_m1_rvalid;
  assign m0_rdata     = ram_dout;
  assign m1_rdata     = ram_dout;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one fixed-priority instance (k=0) and one
// round-robin instance (k=1) share the same stimulus; each has its own RAM.
module tb_dmem_arbiter;
  localparam int AW         = 10;
  localparam int STARVE_MAX = 4;
  localparam int LOCK_MAX   = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;

  logic          fx_m0_gnt, fx_m0_rvalid, fx_m1_gnt, fx_m1_rvalid;
  logic [31:0]   fx_m0_rdata, fx_m1_rdata, fx_ram_din, fx_ram_dout;
  logic [AW-1:0] fx_ram_addr;
  logic [3:0]    fx_ram_wea;
  logic [15:0]   fx_conflict_cnt;
  logic          rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid;
  logic [31:0]   rr_m0_rdata, rr_m1_rdata, rr_ram_din, rr_ram_dout;
  logic [AW-1:0] rr_ram_addr;
  logic [3:0]    rr_ram_wea;
  logic [15:0]   rr_conflict_cnt;

  dmem_arbiter #(.AW(AW), .RR_MODE(0), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) u_fx (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_gnt(fx_m0_gnt),
    .m0_rvalid(fx_m0_rvalid), .m0_rdata(fx_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(fx_m1_gnt),
    .m1_rvalid(fx_m1_rvalid), .m1_rdata(fx_m1_rdata),
    .ram_addr(fx_ram_addr), .ram_din(fx_ram_din), .ram_wea(fx_ram_wea),
    .ram_dout(fx_ram_dout), .conflict_cnt(fx_conflict_cnt)
  );

  dmem_arbiter #(.AW(AW), .RR_MODE(1), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_gnt(rr_m0_gnt),
    .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_gnt(rr_m1_gnt),
    .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
    .ram_addr(rr_ram_addr), .ram_din(rr_ram_din), .ram_wea(rr_ram_wea),
    .ram_dout(rr_ram_dout), .conflict_cnt(rr_conflict_cnt)
  );

  function automatic logic [31:0] pat(int a);
    return 32'(a) * 32'h0101_0107 + 32'h1234_5678;
  endfunction

  // Synchronous byte-writable RAMs, one per instance.
  logic [31:0] mem_fx [1024];
  logic [31:0] mem_rr [1024];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_fx[i] <= pat(i);
      mem_rr[i] <= pat(i);
    end
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (fx_ram_wea[b]) mem_fx[fx_ram_addr][b*8 +: 8] <= fx_ram_din[b*8 +: 8];
      if (rr_ram_wea[b]) mem_rr[rr_ram_addr][b*8 +: 8] <= rr_ram_din[b*8 +: 8];
    end
    fx_ram_dout <= mem_fx[fx_ram_addr];
    rr_ram_dout <= mem_rr[rr_ram_addr];
  end

  // Per-instance views of the outputs, indexed by k.
  logic          d_gnt0 [2], d_gnt1 [2], d_rv0 [2], d_rv1 [2];
  logic [31:0]   d_rd0 [2], d_rd1 [2];
  logic [AW-1:0] d_addr [2];
  logic [3:0]    d_wea [2];
  logic [15:0]   d_conf [2];
  assign d_gnt0[0] = fx_m0_gnt;    assign d_gnt0[1] = rr_m0_gnt;
  assign d_gnt1[0] = fx_m1_gnt;    assign d_gnt1[1] = rr_m1_gnt;
  assign d_rv0[0]  = fx_m0_rvalid; assign d_rv0[1]  = rr_m0_rvalid;
  assign d_rv1[0]  = fx_m1_rvalid; assign d_rv1[1]  = rr_m1_rvalid;
  assign d_rd0[0]  = fx_m0_rdata;  assign d_rd0[1]  = rr_m0_rdata;
  assign d_rd1[0]  = fx_m1_rdata;  assign d_rd1[1]  = rr_m1_rdata;
  assign d_addr[0] = fx_ram_addr;  assign d_addr[1] = rr_ram_addr;
  assign d_wea[0]  = fx_ram_wea;   assign d_wea[1]  = rr_ram_wea;
  assign d_conf[0] = fx_conflict_cnt; assign d_conf[1] = rr_conflict_cnt;

  // Reference model: ownership, tenure length, waiting time of M1.
  int          m_lock_own [2];   // -1 none, else owning master
  int          m_tenure [2];     // grants issued in the current lock
  int          m_starve [2];
  int          m_last [2];
  int          m_conf [2];
  bit          m_rv0 [2], m_rv1 [2];
  logic [31:0] m_rd0 [2], m_rd1 [2];
  logic [31:0] exp_mem [2][1024];
  int          e_win [2];
  logic [AW-1:0] e_addr [2];
  logic [3:0]  e_wea [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock_own[k] = -1; m_tenure[k] = 0; m_starve[k] = 0;
      m_last[k] = 1; m_conf[k] = 0; m_rv0[k] = 0; m_rv1[k] = 0;
    end
  endtask

  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      int w;
      if (m_lock_own[k] == 0) w = m0_req ? 0 : -1;
      else if (m_lock_own[k] == 1) w = m1_req ? 1 : -1;
      else if (m0_req && m1_req) begin
        if (k == 1) w = (m_last[k] == 0) ? 1 : 0;
        else        w = (m_starve[k] >= STARVE_MAX) ? 1 : 0;
      end
      else if (m0_req) w = 0;
      else if (m1_req) w = 1;
      else w = -1;
      e_win[k]  = w;
      e_addr[k] = (w == 1) ? m1_addr : m0_addr;
      e_wea[k]  = (w == 0 && m0_we) ? m0_wstrb : ((w == 1 && m1_we) ? m1_wstrb : 4'h0);
    end
  endtask

  // Applies the current cycle to the model, then moves to posedge+1.
  task automatic advance();
    predict();
    for (int k = 0; k < 2; k++) begin
      int w;
      bit own_req, own_lock;
      w = e_win[k];
      if (m_lock_own[k] >= 0) begin
        own_req  = (m_lock_own[k] == 0) ? m0_req  : m1_req;
        own_lock = (m_lock_own[k] == 0) ? m0_lock : m1_lock;
        if (!own_req || !own_lock) m_lock_own[k] = -1;
        else begin
          m_tenure[k]++;
          if (m_tenure[k] >= LOCK_MAX) m_lock_own[k] = -1;
        end
      end else if (LOCK_MAX > 1 && ((w == 0 && m0_lock) || (w == 1 && m1_lock))) begin
        m_lock_own[k] = w;
        m_tenure[k]   = 1;
      end
      if (m1_req && w != 1) m_starve[k] = (m_starve[k] < STARVE_MAX) ? m_starve[k] + 1 : STARVE_MAX;
      else m_starve[k] = 0;
      if (w >= 0) m_last[k] = w;
      if (m0_req && m1_req && m_conf[k] < 65535) m_conf[k]++;
      m_rv0[k] = (w == 0 && !m0_we);
      m_rv1[k] = (w == 1 && !m1_we);
      if (m_rv0[k]) m_rd0[k] = exp_mem[k][m0_addr];
      if (m_rv1[k]) m_rd1[k] = exp_mem[k][m1_addr];
      for (int b = 0; b < 4; b++) begin
        if (w == 0 && m0_we && m0_wstrb[b]) exp_mem[k][m0_addr][b*8 +: 8] = m0_wdata[b*8 +: 8];
        if (w == 1 && m1_we && m1_wstrb[b]) exp_mem[k][m1_addr][b*8 +: 8] = m1_wdata[b*8 +: 8];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1; m1_req = 1; m0_we = 1; m0_wstrb = 4'hF;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d_gnt0[k] !== 1'b0 || d_gnt1[k] !== 1'b0) begin n_fail++; $display("FAIL reset_gnt k=%0d got %b%b exp 00", k, d_gnt0[k], d_gnt1[k]); end
      n_checks++; if (d_wea[k] !== 4'h0) begin n_fail++; $display("FAIL reset_wea k=%0d got %h exp 0", k, d_wea[k]); end
      n_checks++; if (d_rv0[k] !== 1'b0 || d_rv1[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid k=%0d got %b%b exp 00", k, d_rv0[k], d_rv1[k]); end
      n_checks++; if (d_conf[k] !== 16'h0) begin n_fail++; $display("FAIL reset_conflict k=%0d got %0d exp 0", k, d_conf[k]); end
    end
    idle_inputs();
    @(negedge clk);
    rstn = 1;
    model_reset();
    advance();
  endtask

  task automatic test_round_robin();
    idle_inputs();
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      m0_addr = AW'(i); m1_addr = AW'(i + 8);
      @(negedge clk);
      n_checks++; if (rr_m0_gnt !== ((i % 2) == 0) || rr_m1_gnt !== ((i % 2) == 1)) begin n_fail++; $display("FAIL rr_alternate cycle=%0d got m0=%b m1=%b exp m0=%b", i, rr_m0_gnt, rr_m1_gnt, (i % 2) == 0); end
      n_checks++; if (rr_conflict_cnt !== 16'(i)) begin n_fail++; $display("FAIL rr_conflict cycle=%0d got %0d exp %0d", i, rr_conflict_cnt, i); end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_single_read();
    idle_inputs();
    m0_req = 1; m0_addr = 10'h010;
    @(negedge clk);
    n_checks++; if (fx_m0_gnt !== 1'b1 || fx_m1_gnt !== 1'b0) begin n_fail++; $display("FAIL single_read_gnt got m0=%b m1=%b exp m0=1 m1=0", fx_m0_gnt, fx_m1_gnt); end
    n_checks++; if (fx_ram_addr !== 10'h010) begin n_fail++; $display("FAIL single_read_addr got %h exp 010", fx_ram_addr); end
    n_checks++; if (fx_ram_wea !== 4'h0) begin n_fail++; $display("FAIL single_read_wea got %h exp 0", fx_ram_wea); end
    advance();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (fx_m0_rvalid !== 1'b1 || fx_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_read_rvalid got m0=%b m1=%b exp m0=1 m1=0", fx_m0_rvalid, fx_m1_rvalid); end
    n_checks++; if (fx_m0_rdata !== pat(16)) begin n_fail++; $display("FAIL single_read_rdata got %h exp %h", fx_m0_rdata, pat(16)); end
    advance();
    @(negedge clk);
    n_checks++; if (fx_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_read_rvalid_drop got %b exp 0", fx_m0_rvalid); end
    advance();
  endtask

  task automatic test_fixed_priority();
    int c0;
    idle_inputs();
    advance();
    c0 = m_conf[0];
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (fx_m1_gnt !== (i == 4 || i == 9) || fx_m0_gnt !== !(i == 4 || i == 9)) begin n_fail++; $display("FAIL starve_guard cycle=%0d got m0=%b m1=%b", i, fx_m0_gnt, fx_m1_gnt); end
      n_checks++; if (fx_conflict_cnt !== 16'(c0 + i)) begin n_fail++; $display("FAIL fixed_conflict cycle=%0d got %0d exp %0d", i, fx_conflict_cnt, c0 + i); end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_lock();
    idle_inputs();
    advance();
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 10'h020; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    for (int c = 0; c < 9; c++) begin
      if (c >= 1) begin m0_req = 1; m0_we = 0; m0_addr = 10'h030; end
      @(negedge clk);
      n_checks++; if (fx_m1_gnt !== (c < 8) || fx_m0_gnt !== (c == 8)) begin n_fail++; $display("FAIL lock_hold cycle=%0d got m0=%b m1=%b", c, fx_m0_gnt, fx_m1_gnt); end
      n_checks++; if (fx_ram_wea !== ((c < 8) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL lock_wea cycle=%0d got %h", c, fx_ram_wea); end
      advance();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (fx_m0_rvalid !== 1'b1 || fx_m0_rdata !== pat(16'h030)) begin n_fail++; $display("FAIL lock_m0_read got v=%b d=%h exp v=1 d=%h", fx_m0_rvalid, fx_m0_rdata, pat(16'h030)); end
    advance();
  endtask

  task automatic test_byte_write();
    logic [31:0] expv;
    expv = {pat(10'h3FF) >> 16, 16'hCCDD};
    idle_inputs();
    m0_req = 1; m0_we = 1; m0_addr = 10'h3FF; m0_wdata = 32'hAABB_CCDD; m0_wstrb = 4'b0011;
    @(negedge clk);
    n_checks++; if (fx_ram_wea !== 4'b0011 || fx_ram_addr !== 10'h3FF || fx_ram_din !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL byte_write_port got wea=%b addr=%h din=%h", fx_ram_wea, fx_ram_addr, fx_ram_din); end
    advance();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (fx_ram_wea !== 4'h0 || fx_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL byte_write_once got wea=%b rvalid=%b exp 0", fx_ram_wea, fx_m0_rvalid); end
    advance();
    m0_req = 1; m0_addr = 10'h3FF;
    advance();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (fx_m0_rvalid !== 1'b1 || fx_m0_rdata !== expv) begin n_fail++; $display("FAIL byte_write_readback got v=%b d=%h exp %h", fx_m0_rvalid, fx_m0_rdata, expv); end
    advance();
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    advance();
    m0_req = 1; m0_addr = 10'h010; m1_req = 1; m1_addr = 10'h011;
    @(negedge clk);
    n_checks++; if (fx_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got %b exp 1", fx_m0_gnt); end
    advance();
    n_checks++; if (fx_m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_rvalid got %b exp 1", fx_m0_rvalid); end
    rstn = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (d_rv0[k] !== 1'b0 || d_rv1[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid k=%0d got %b%b exp 00", k, d_rv0[k], d_rv1[k]); end
      n_checks++; if (d_gnt0[k] !== 1'b0 || d_gnt1[k] !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt_off k=%0d got %b%b exp 00", k, d_gnt0[k], d_gnt1[k]); end
      n_checks++; if (d_conf[k] !== 16'h0) begin n_fail++; $display("FAIL midrst_conflict k=%0d got %0d exp 0", k, d_conf[k]); end
    end
    idle_inputs();
    @(negedge clk);
    rstn = 1;
    model_reset();
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      m0_req = ($urandom_range(0, 9) < 7); m0_we = $urandom_range(0, 1) != 0;
      m0_lock = ($urandom_range(0, 3) == 0); m0_addr = AW'($urandom_range(0, 15));
      m0_wdata = $urandom; m0_wstrb = 4'($urandom_range(0, 15));
      m1_req = ($urandom_range(0, 9) < 7); m1_we = $urandom_range(0, 1) != 0;
      m1_lock = ($urandom_range(0, 3) == 0); m1_addr = AW'($urandom_range(0, 15));
      m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
      @(negedge clk);
      predict();
      for (int k = 0; k < 2; k++) begin
        n_checks++; if (d_gnt0[k] !== (e_win[k] == 0) || d_gnt1[k] !== (e_win[k] == 1)) begin n_fail++; $display("FAIL rand_gnt k=%0d n=%0d got %b%b exp win=%0d", k, n, d_gnt0[k], d_gnt1[k], e_win[k]); end
        n_checks++; if (d_addr[k] !== e_addr[k] || d_wea[k] !== e_wea[k]) begin n_fail++; $display("FAIL rand_port k=%0d n=%0d got %h/%h exp %h/%h", k, n, d_addr[k], d_wea[k], e_addr[k], e_wea[k]); end
        n_checks++; if (d_rv0[k] !== m_rv0[k] || d_rv1[k] !== m_rv1[k]) begin n_fail++; $display("FAIL rand_rvalid k=%0d n=%0d got %b%b exp %b%b", k, n, d_rv0[k], d_rv1[k], m_rv0[k], m_rv1[k]); end
        if (m_rv0[k]) begin
          n_checks++; if (d_rd0[k] !== m_rd0[k]) begin n_fail++; $display("FAIL rand_rdata0 k=%0d n=%0d got %h exp %h", k, n, d_rd0[k], m_rd0[k]); end
        end
        if (m_rv1[k]) begin
          n_checks++; if (d_rd1[k] !== m_rd1[k]) begin n_fail++; $display("FAIL rand_rdata1 k=%0d n=%0d got %h exp %h", k, n, d_rd1[k], m_rd1[k]); end
        end
        n_checks++; if (d_conf[k] !== 16'(m_conf[k])) begin n_fail++; $display("FAIL rand_conflict k=%0d n=%0d got %0d exp %0d", k, n, d_conf[k], m_conf[k]); end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 1024; i++) exp_mem[k][i] = pat(i);
    model_reset();
    idle_inputs();
    test_reset();
    test_round_robin();
    test_single_read();
    test_fixed_priority();
    test_lock();
    test_byte_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
